// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg -- shared types and constants for the UART transmit stage. rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    function automatic int cnt_width(input int clks_per_bit);
        int w;
        w = $clog2(clks_per_bit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_stage_baud_cnt.sv
// ============================================================================
// uart_baud_cnt -- bit-period counter, one-cycle tick on wrap. rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-runs while idle; the accept clear aligns the first bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            if (clear || (cnt == CNT_MAX)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign tick = ena && !clear && (cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/uart_tx_stage.sv
// ============================================================================
// uart_tx_stage -- valid/ready byte in, 8N1 (optional even parity) out. rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_stage
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       busy,
    output logic [2:0] state_dbg
);

    tx_state_t  state;
    tx_state_t  state_next;
    tx_state_t  after_data;
    logic [7:0] shreg;
    logic       parity_bit;
    logic [2:0] bit_cnt;
    logic       accept;
    logic       tick;
    logic       last_bit;
    logic       line_next;

    assign tx_ready  = (state == ST_IDLE) && ena;
    assign accept    = tx_valid && tx_ready;
    assign last_bit  = (bit_cnt == 3'(DATA_BITS - 1));
    assign state_dbg = state;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (accept),
        .tick  (tick)
    );

    if (PARITY_EN != 0) begin : g_parity
        assign after_data = ST_PARITY;
    end else begin : g_no_parity
        assign after_data = ST_STOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)           state_next = ST_START;
            ST_START:  if (tick)             state_next = ST_DATA;
            ST_DATA:   if (tick && last_bit) state_next = after_data;
            ST_PARITY: if (tick)             state_next = ST_STOP;
            ST_STOP:   if (tick)             state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // The line is registered from the current state, so it lags the state
    // register by one cycle: the start bit appears one edge after accept.
    always_comb begin
        line_next = LINE_IDLE;
        case (state)
            ST_START:  line_next = 1'b0;
            ST_DATA:   line_next = shreg[0];
            ST_PARITY: line_next = parity_bit;
            default:   line_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_serial  <= LINE_IDLE;
            busy       <= 1'b0;
            shreg      <= 8'h00;
            parity_bit <= 1'b0;
            bit_cnt    <= 3'd0;
        end else if (ena) begin
            tx_serial <= line_next;
            busy      <= (state_next != ST_IDLE);
            if (accept) begin
                shreg      <= tx_data;
                parity_bit <= ^tx_data;
                bit_cnt    <= 3'd0;
            end else if ((state == ST_DATA) && tick) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stage.sv
// ============================================================================
// tb_uart_tx_stage -- directed self-checking bench for uart_tx_stage. rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] tx_data;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       ser0, ser1;
    logic       busy0, busy1;
    logic [2:0] st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tr [0:127];
    logic       rd [0:127];
    logic       bz [0:127];
    logic [2:0] st [0:127];
    int         busy_cnt;

    always #5 clk = ~clk;

    uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(valid0),
        .tx_ready(ready0), .tx_serial(ser0), .busy(busy0), .state_dbg(st0)
    );

    uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tx_data(tx_data), .tx_valid(valid1),
        .tx_ready(ready1), .tx_serial(ser1), .busy(busy1), .state_dbg(st1)
    );

    // Waits (bounded) for ready, offers one byte, records ncyc negedge samples.
    // Sample 0 is the negedge just before the accepting posedge.
    task automatic send_frame(input bit sel, input logic [7:0] d, input int ncyc,
                              input int ena_at, input int ena_len);
        int n;
        n = 0;
        while (!(sel ? ready1 : ready0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL ready_timeout: tx_ready stayed %b, expected 1", sel ? ready1 : ready0);
        end
        tx_data  = d;
        valid0   = !sel;
        valid1   = sel;
        busy_cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            tr[i] = sel ? ser1 : ser0;
            rd[i] = sel ? ready1 : ready0;
            st[i] = sel ? st1 : st0;
            if (sel ? busy1 : busy0) busy_cnt++;
            if (i == 1) begin
                valid0 = 1'b0;
                valid1 = 1'b0;
            end
            if (i == ena_at)           ena = 1'b0;
            if (i == ena_at + ena_len) ena = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; valid0 = 1'b0; valid1 = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ser0, busy0, ready0, st0} !== 6'b101000) begin
            n_fail++;
            $display("FAIL reset_dut0: {ser,busy,ready,state}=%b expected 101000", {ser0, busy0, ready0, st0});
        end
        n_checks++;
        if ({ser1, busy1, ready1, st1} !== 6'b101000) begin
            n_fail++;
            $display("FAIL reset_dut1: {ser,busy,ready,state}=%b expected 101000", {ser1, busy1, ready1, st1});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ser0, busy0, ready0, st0} !== 6'b101000) begin
            n_fail++;
            $display("FAIL idle_after_release: {ser,busy,ready,state}=%b expected 101000", {ser0, busy0, ready0, st0});
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] exp;
        logic [3:0] got;
        exp = 10'b1101001010;   // 0xA5: 0,1,0,1,0,0,1,0,1,1
        send_frame(1'b0, 8'hA5, 48, -10, 0);
        n_checks++;
        if ({tr[0], tr[1]} !== 2'b11) begin
            n_fail++;
            $display("FAIL a5_latency: line before start %b expected 11", {tr[0], tr[1]});
        end
        n_checks++;
        if (st[1] !== 3'd1) begin
            n_fail++;
            $display("FAIL a5_state_start: state %0d expected 1", st[1]);
        end
        for (int k = 0; k < 10; k++) begin
            got = {tr[4*k+2], tr[4*k+3], tr[4*k+4], tr[4*k+5]};
            n_checks++;
            if (got !== {4{exp[k]}}) begin
                n_fail++;
                $display("FAIL a5_bit%0d: line %b expected %b", k, got, {4{exp[k]}});
            end
        end
        n_checks++;
        if (tr[42] !== 1'b1) begin
            n_fail++;
            $display("FAIL a5_idle_after: line %b expected 1", tr[42]);
        end
        n_checks++;
        if (busy_cnt !== 40) begin
            n_fail++;
            $display("FAIL a5_busy_len: busy cycles %0d expected 40", busy_cnt);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp [0:1];
        logic [7:0]  dat [0:1];
        logic [3:0]  got;
        dat[0] = 8'h07; exp[0] = 11'b11000001110;   // parity 1
        dat[1] = 8'h03; exp[1] = 11'b10000000110;   // parity 0
        for (int f = 0; f < 2; f++) begin
            send_frame(1'b1, dat[f], 52, -10, 0);
            for (int k = 0; k < 11; k++) begin
                got = {tr[4*k+2], tr[4*k+3], tr[4*k+4], tr[4*k+5]};
                n_checks++;
                if (got !== {4{exp[f][k]}}) begin
                    n_fail++;
                    $display("FAIL parity_%h_bit%0d: line %b expected %b", dat[f], k, got, {4{exp[f][k]}});
                end
            end
            n_checks++;
            if (busy_cnt !== 44) begin
                n_fail++;
                $display("FAIL parity_%h_busy_len: busy cycles %0d expected 44", dat[f], busy_cnt);
            end
            n_checks++;
            if (tr[46] !== 1'b1) begin
                n_fail++;
                $display("FAIL parity_%h_idle_after: line %b expected 1", dat[f], tr[46]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a, exp_b;
        logic [3:0] got_a, got_b;
        logic       pend;
        logic       tail_ok;
        int         acc, bcnt, n;
        exp_a = 10'b1010101010;   // 0x55
        exp_b = 10'b1101010100;   // 0xAA
        acc = 0; bcnt = 0; pend = 1'b0; n = 0;
        while (!ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_data = 8'h55;
        valid0  = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tr[i] = ser0;
            bz[i] = busy0;
            if (busy0) bcnt++;
            if (pend) begin
                if (acc == 1) tx_data = 8'hAA;
                else          valid0  = 1'b0;
            end
            pend = valid0 && ready0;
            if (pend) acc++;
            @(negedge clk);
        end
        valid0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            got_a = {tr[4*k+2], tr[4*k+3], tr[4*k+4], tr[4*k+5]};
            got_b = {tr[4*k+43], tr[4*k+44], tr[4*k+45], tr[4*k+46]};
            n_checks++;
            if (got_a !== {4{exp_a[k]}}) begin
                n_fail++;
                $display("FAIL b2b_55_bit%0d: line %b expected %b", k, got_a, {4{exp_a[k]}});
            end
            n_checks++;
            if (got_b !== {4{exp_b[k]}}) begin
                n_fail++;
                $display("FAIL b2b_aa_bit%0d: line %b expected %b", k, got_b, {4{exp_b[k]}});
            end
        end
        n_checks++;
        if ({tr[42], bz[41]} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_gap: {line,busy} in gap %b expected 10", {tr[42], bz[41]});
        end
        tail_ok = 1'b1;
        for (int i = 83; i < 90; i++) if (tr[i] !== 1'b1) tail_ok = 1'b0;
        n_checks++;
        if (tail_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_third_frame: idle tail ok=%b expected 1", tail_ok);
        end
        n_checks++;
        if (acc !== 2) begin
            n_fail++;
            $display("FAIL b2b_accepts: accepts %0d expected 2", acc);
        end
        n_checks++;
        if (bcnt !== 80) begin
            n_fail++;
            $display("FAIL b2b_busy_len: busy cycles %0d expected 80", bcnt);
        end
    endtask

    task automatic test_ena_gating();
        localparam int D = 16;
        logic [9:0] exp;
        int         e;
        logic       x;
        exp = 10'b1110000110;   // 0xC3
        send_frame(1'b0, 8'hC3, 56, D, 7);
        for (int i = 0; i < 56; i++) begin
            e = (i <= D) ? i : ((i <= D + 7) ? D : i - 7);
            x = (e < 2 || e > 41) ? 1'b1 : exp[(e-2)/4];
            n_checks++;
            if (tr[i] !== x) begin
                n_fail++;
                $display("FAIL ena_line_s%0d: line %b expected %b", i, tr[i], x);
            end
        end
        n_checks++;
        if ({st[D], st[D+7]} !== {3'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL ena_state_frozen: states %0d,%0d expected 2,2", st[D], st[D+7]);
        end
        n_checks++;
        if (rd[D+3] !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_ready_low: tx_ready %b expected 0", rd[D+3]);
        end
        n_checks++;
        if (busy_cnt !== 47) begin
            n_fail++;
            $display("FAIL ena_busy_len: busy cycles %0d expected 47", busy_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        logic [3:0] got;
        logic       quiet;
        int         n;
        exp = 10'b1001111000;   // 0x3C
        n = 0;
        while (!ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_data = 8'hF0;
        valid0  = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i == 1) valid0 = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (ser0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre_bit3: line %b expected 0", ser0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser0, busy0, st0} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_async: {ser,busy,state}=%b expected 10000", {ser0, busy0, st0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ser0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_no_retransmit: quiet=%b expected 1", quiet);
        end
        send_frame(1'b0, 8'h3C, 48, -10, 0);
        for (int k = 0; k < 10; k++) begin
            got = {tr[4*k+2], tr[4*k+3], tr[4*k+4], tr[4*k+5]};
            n_checks++;
            if (got !== {4{exp[k]}}) begin
                n_fail++;
                $display("FAIL rst_3c_bit%0d: line %b expected %b", k, got, {4{exp[k]}});
            end
        end
        n_checks++;
        if (busy_cnt !== 40) begin
            n_fail++;
            $display("FAIL rst_3c_busy_len: busy cycles %0d expected 40", busy_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_ena_gating();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
